// File: rtl/uart_rx_fifo_tx_pkg.sv
// Shared definitions for the receive-FIFO-transmit buffering stage.
//   rd_state_e : read FSM state encoding (2-bit)
//   CHAR_CR    : line terminator byte used by the optional line mode
//   is_cr()    : helper that flags a line-terminator byte
package uart_rx_fifo_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_WAIT  = 2'd3
  } rd_state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;

  function automatic logic is_cr(input logic [7:0] b);
    return (b == CHAR_CR);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_tx_if.sv
// Bundle of receiver-side, transmitter-side and status signals of uart_rx_fifo_tx.
//   rcv/rx_data       : byte strobe and data from the serial receiver
//   tx_ready/tx_start : transmitter idle flag and send request
//   tx_data           : byte presented to the transmitter
//   count/full/empty  : FIFO occupancy status
//   overflow/ovf_clr  : sticky dropped-byte flag and its synchronous clear
// master: the surrounding system (receiver, transmitter, status reader)
// slave : the buffering stage itself
interface uart_rx_fifo_tx_if #(
  parameter int unsigned DEPTH = 16
) ();
  localparam int unsigned AW = $clog2(DEPTH);

  logic          rcv;
  logic [7:0]    rx_data;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clr;

  modport master (
    output rcv, rx_data, tx_ready, ovf_clr,
    input  tx_start, tx_data, count, full, empty, overflow
  );

  modport slave (
    input  rcv, rx_data, tx_ready, ovf_clr,
    output tx_start, tx_data, count, full, empty, overflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// Synchronous byte FIFO: storage, wrap-around pointers and registered status.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i at the write pointer (caller guarantees room)
//   pop_i     : advance the read pointer (caller guarantees data)
//   wdata_i   : byte to store
//   rdata_o   : byte at the read pointer (combinational)
//   count_o   : occupancy 0..DEPTH, registered
//   full_o    : count == DEPTH, registered
//   empty_o   : count == 0, registered
module sync_fifo_mem #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx_fifo_tx.sv
// Buffering stage between the serial receiver and the serial transmitter.
// Each rcv pulse stores rx_data in a FIFO; a read FSM drains the FIFO through
// the transmitter start/ready handshake (IDLE -> FETCH -> SEND -> WAIT).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_rx_fifo_tx_if.slave (rcv, rx_data, tx_ready, ovf_clr in;
//              tx_start, tx_data, count, full, empty, overflow out)
// Optional feature, macro LINE_MODE_EN: bytes are held until a CR (0x0D) has
// been buffered, or the FIFO is full, so whole lines go out back to back.
module uart_rx_fifo_tx
  import uart_rx_fifo_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_rx_fifo_tx_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  rd_state_e  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       overflow_q, overflow_d;
  logic       push, pop, ovf_event, release_ok;
  logic [7:0] rdata;
  logic       fifo_full, fifo_empty;

  sync_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.rx_data),
    .rdata_o (rdata),
    .count_o (bus.count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The only pop is the FETCH cycle; a write while full is still accepted
  // when that pop frees a slot in the same cycle.
  assign pop       = (state_q == S_FETCH);
  assign push      = bus.rcv && (!fifo_full || pop);
  assign ovf_event = bus.rcv && fifo_full && !pop;

`ifdef LINE_MODE_EN
  logic [AW:0] term_cnt_q, term_cnt_d;
  logic        term_inc, term_dec;

  assign term_inc = push && is_cr(bus.rx_data);
  assign term_dec = pop && is_cr(rdata);

  always_comb begin
    term_cnt_d = term_cnt_q;
    if (term_inc && !term_dec) begin
      term_cnt_d = term_cnt_q + (AW+1)'(1);
    end else if (term_dec && !term_inc) begin
      term_cnt_d = term_cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_cnt_q <= '0;
    end else begin
      term_cnt_q <= term_cnt_d;
    end
  end

  // A full FIFO without a terminator is released to avoid deadlock.
  assign release_ok = !fifo_empty && ((term_cnt_q != '0) || fifo_full);
`else
  assign release_ok = !fifo_empty;
`endif

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (release_ok && bus.tx_ready) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        tx_data_d = rdata;
        state_d   = S_SEND;
      end
      S_SEND: begin
        // Ready going low means the transmitter has taken the byte.
        if (!bus.tx_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set wins over a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Decoded from the state register so reset removes it immediately.
  assign bus.tx_start = (state_q == S_SEND);
  assign bus.tx_data  = tx_data_q;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo_tx.sv
module tb_uart_rx_fifo_tx;
  import uart_rx_fifo_tx_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_fifo_tx_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo_tx #(
    .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb[$];

  // Transmitter model controls.
  bit hold      = 1'b0;
  bit no_accept = 1'b0;
  int busy_len  = 1;
  int busy      = 0;
  int accepts   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: takes the byte on the first falling edge where tx_start
  // is seen, drops ready, stays busy for busy_len cycles.
  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
      bus.tx_ready = !hold;
    end else if (hold) begin
      bus.tx_ready = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) bus.tx_ready = 1'b1;
    end else begin
      bus.tx_ready = 1'b1;
      if (bus.tx_start === 1'b1 && !no_accept) begin
        chk("sb_has_expected_byte", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("tx_data", bus.tx_data, sb.pop_front());
        accepts++;
        bus.tx_ready = 1'b0;
        busy = busy_len;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit accepted);
    @(posedge clk); #1;
    bus.rcv = 1'b1;
    bus.rx_data = b;
    if (accepted) sb.push_back(b);
    @(posedge clk); #1;
    bus.rcv = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int i = 0;
    while (sb.size() != 0 && i < bound) begin
      @(posedge clk);
      i++;
    end
    chk(tag, 32'(sb.size() == 0), 1);
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int peak;
    int i;
    int acc0;
    bit seen;

    bus.rcv = 1'b0;
    bus.rx_data = 8'h00;
    bus.ovf_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

`ifndef LINE_MODE_EN
    // Single byte, latency check.
    busy_len = 1;
    send_byte(8'h41, 1'b1);
    chk("single_count1", bus.count, 1);
    chk("single_empty0", bus.empty, 0);
    chk("single_start_n1", bus.tx_start, 0);
    @(posedge clk); #1;
    chk("single_start_n2", bus.tx_start, 0);
    @(posedge clk); #1;
    chk("single_start_n3", bus.tx_start, 1);
    chk("single_data_n3", bus.tx_data, 8'h41);
    chk("single_count0", bus.count, 0);
    wait_drain(20, "single_drain");
    chk("single_empty1", bus.empty, 1);

    // Burst against a slow transmitter.
    busy_len = 50;
    peak = 0;
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h31 + 8'(k), 1'b1);
      if (int'(bus.count) > peak) peak = int'(bus.count);
    end
    chk("burst_peak_4_or_5", 32'(peak == 4 || peak == 5), 1);
    wait_drain(600, "burst_drain");
    chk("burst_overflow", bus.overflow, 0);

    // Overflow: transmitter blocked, DEPTH+2 writes.
    busy_len = 2;
    hold = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < int'(DEPTH); k++) send_byte(8'h80 + 8'(k), 1'b1);
    chk("ovf_full", bus.full, 1);
    chk("ovf_count_depth", bus.count, DEPTH);
    chk("ovf_not_yet", bus.overflow, 0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hF1, 1'b0);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_count_held", bus.count, DEPTH);
    hold = 1'b0;
    wait_drain(400, "ovf_drain");
    chk("ovf_empty_after", bus.empty, 1);
    @(posedge clk); #1 bus.ovf_clr = 1'b1;
    @(posedge clk); #1 bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.overflow, 0);

    // Full boundary: write coincident with the FETCH pop.
    hold = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < int'(DEPTH); k++) send_byte(8'h60 + 8'(k), 1'b1);
    chk("bnd_full", bus.full, 1);
    hold = 1'b0;
    i = 0;
    @(posedge clk); #1;
    while (dut.state_q != S_FETCH && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk("bnd_fetch_reached", 32'(dut.state_q == S_FETCH), 1);
    bus.rcv = 1'b1;
    bus.rx_data = 8'hEE;
    sb.push_back(8'hEE);
    @(posedge clk); #1;
    bus.rcv = 1'b0;
    chk("bnd_count_depth", bus.count, DEPTH);
    chk("bnd_full_kept", bus.full, 1);
    chk("bnd_no_overflow", bus.overflow, 0);
    wait_drain(400, "bnd_drain");

    // Reset while tx_start is high.
    no_accept = 1'b1;
    send_byte(8'h5A, 1'b1);
    i = 0;
    while (bus.tx_start !== 1'b1 && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk("rsend_start_seen", bus.tx_start, 1);
    #1 rst = 1'b1;
    #1;
    chk("rsend_start_drop", bus.tx_start, 0);
    chk("rsend_count", bus.count, 0);
    chk("rsend_empty", bus.empty, 1);
    chk("rsend_idle", 32'(dut.state_q == S_IDLE), 1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    no_accept = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) seen = 1'b1;
    end
    chk("rsend_no_more_tx", seen, 0);
`else
    // Line mode: bytes held until a terminator is buffered.
    busy_len = 2;
    acc0 = accepts;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) seen = 1'b1;
    end
    chk("line_held_no_start", seen, 0);
    chk("line_held_count", bus.count, 2);
    send_byte(CHAR_CR, 1'b1);
    wait_drain(200, "line_drain");
    chk("line_accepts", accepts - acc0, 3);
    chk("line_term_cnt_zero", 32'(dut.term_cnt_q), 0);
    chk("line_empty", bus.empty, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
